// File: rtl/mem_xfer_pkg.sv
// Shared definitions for the SRAM-to-SRAM block copy controller.
// The checksum feature is compiled in only when XFER_CHECKSUM_EN is defined.
package mem_xfer_pkg;

    localparam int XFER_DATA_W = 8;
    localparam int XFER_ADDR_W = 3;

    // Controller states; explicit 2-bit encodings keep the register layout fixed.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRIME  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } xfer_state_e;

endpackage

// File: rtl/xfer_addr_ctr.sv
// Loadable address pointer that counts upward and wraps naturally at DEPTH.
// Used once as the source read pointer and once as the destination write pointer.
module xfer_addr_ctr
    import mem_xfer_pkg::*;
#(
    parameter int ADDR_W = XFER_ADDR_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_base,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_addr
);

    logic [ADDR_W-1:0] r_addr;

    // Load the base address on a new transfer, otherwise step by one when asked.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_addr <= '0;
        end else if (i_load) begin
            r_addr <= i_base;
        end else if (i_inc) begin
            r_addr <= r_addr + ADDR_W'(1);
        end
    end

    assign o_addr = r_addr;

endmodule

// File: rtl/mem_xfer_ctrl.sv
// Block copy controller: streams len words from SRAM A into SRAM B, one word
// per cycle after a single priming read. Host accesses reach A only while idle.
// Optional running checksum of copied words: define XFER_CHECKSUM_EN.
module mem_xfer_ctrl
    import mem_xfer_pkg::*;
#(
    parameter int DATA_W = XFER_DATA_W,
    parameter int ADDR_W = XFER_ADDR_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [ADDR_W:0]   len,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_din,
    output logic [DATA_W-1:0] host_dout,
    output logic              host_rej,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum,
    output logic [ADDR_W-1:0] addr_a,
    output logic              we_a,
    output logic [DATA_W-1:0] din_a,
    input  logic [DATA_W-1:0] dout_a,
    output logic [ADDR_W-1:0] addr_b,
    output logic              we_b,
    output logic [DATA_W-1:0] din_b
);

    xfer_state_e       r_state;
    xfer_state_e       w_next;
    logic [ADDR_W:0]   r_remain;
    logic              r_host_rej;
    logic              w_accept;
    logic              w_go;
    logic              w_src_inc;
    logic              w_dst_inc;
    logic [ADDR_W-1:0] w_src_addr;
    logic [ADDR_W-1:0] w_dst_addr;

    assign w_accept = start && (r_state == ST_IDLE);
    assign w_go     = w_accept && (len != '0);

    // The read pointer runs one word ahead of the writer and stops on the last word.
    assign w_src_inc = ((r_state == ST_PRIME)  && (r_remain > (ADDR_W+1)'(1))) ||
                       ((r_state == ST_STREAM) && (r_remain > (ADDR_W+1)'(2)));
    assign w_dst_inc = (r_state == ST_STREAM);

    xfer_addr_ctr #(.ADDR_W(ADDR_W)) u_src_ctr (
        .clock   (clock),
        .reset_n (reset_n),
        .i_load  (w_go),
        .i_base  (src_base),
        .i_inc   (w_src_inc),
        .o_addr  (w_src_addr)
    );

    xfer_addr_ctr #(.ADDR_W(ADDR_W)) u_dst_ctr (
        .clock   (clock),
        .reset_n (reset_n),
        .i_load  (w_go),
        .i_base  (dst_base),
        .i_inc   (w_dst_inc),
        .o_addr  (w_dst_addr)
    );

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Words still to be written, counting the one in flight this cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_remain <= '0;
        end else if (w_go) begin
            r_remain <= len;
        end else if (r_state == ST_STREAM) begin
            r_remain <= r_remain - (ADDR_W+1)'(1);
        end
    end

    // Flag host writes that arrive while the copy engine owns memory A.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_host_rej <= 1'b0;
        end else begin
            r_host_rej <= host_we && (r_state != ST_IDLE);
        end
    end

    // Next-state logic plus the memory port steering for each state.
    always_comb begin
        w_next = r_state;
        addr_a = w_src_addr;
        we_a   = 1'b0;
        din_a  = '0;
        we_b   = 1'b0;
        din_b  = '0;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                addr_a = host_addr;
                we_a   = host_we;
                din_a  = host_din;
                if (w_accept) begin
                    w_next = w_go ? ST_PRIME : ST_DONE;
                end
            end
            ST_PRIME: begin
                busy   = 1'b1;
                w_next = ST_STREAM;
            end
            ST_STREAM: begin
                busy  = 1'b1;
                we_b  = 1'b1;
                din_b = dout_a;
                if (r_remain == (ADDR_W+1)'(1)) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign addr_b    = w_dst_addr;
    assign host_dout = dout_a;
    assign host_rej  = r_host_rej;

`ifdef XFER_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;

    // Running sum of every word written to B, restarted by each accepted start.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= '0;
        end else if (r_state == ST_STREAM) begin
            r_checksum <= r_checksum + din_b;
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_mem_xfer_ctrl.sv
// Bench for mem_xfer_ctrl with behavioural SRAM A and SRAM B models.
// Checksum expectations follow XFER_CHECKSUM_EN when it is defined for the build.
module tb_mem_xfer_ctrl;

    typedef struct packed {
        logic [2:0] addr;
        logic [7:0] data;
    } wr_t;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start;
    logic [2:0] src_base;
    logic [2:0] dst_base;
    logic [3:0] len;
    logic       host_we;
    logic [2:0] host_addr;
    logic [7:0] host_din;
    logic [7:0] host_dout;
    logic       host_rej;
    logic       busy;
    logic       done;
    logic [7:0] checksum;
    logic [2:0] addr_a;
    logic       we_a;
    logic [7:0] din_a;
    logic [7:0] dout_a;
    logic [2:0] addr_b;
    logic       we_b;
    logic [7:0] din_b;

    logic [7:0] memA [0:7];
    logic [7:0] memB [0:7];
    logic [7:0] modelA [0:7];
    logic [7:0] modelB [0:7];

    wr_t expQ[$];
    wr_t monEntry;
    int  compared = 0;
    int  mismatched = 0;

    mem_xfer_ctrl dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .src_base  (src_base),
        .dst_base  (dst_base),
        .len       (len),
        .host_we   (host_we),
        .host_addr (host_addr),
        .host_din  (host_din),
        .host_dout (host_dout),
        .host_rej  (host_rej),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum),
        .addr_a    (addr_a),
        .we_a      (we_a),
        .din_a     (din_a),
        .dout_a    (dout_a),
        .addr_b    (addr_b),
        .we_b      (we_b),
        .din_b     (din_b)
    );

    always #5 clock = ~clock;

    // SRAM A: synchronous write, registered read.
    always @(posedge clock) begin
        if (we_a) memA[addr_a] <= din_a;
        dout_a <= memA[addr_a];
    end

    // SRAM B: synchronous write.
    always @(posedge clock) begin
        if (we_b) memB[addr_b] <= din_b;
    end

    // Scoreboard: each B write must match the oldest expected write.
    always @(negedge clock) begin
        if (reset_n === 1'b1 && we_b === 1'b1) begin
            compared++;
            if (expQ.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL sb_write: got addr_b=%0d din_b=%02h, required no write", addr_b, din_b);
            end else begin
                monEntry = expQ.pop_front();
                if (addr_b !== monEntry.addr || din_b !== monEntry.data) begin
                    mismatched++;
                    $display("[TB] FAIL sb_write: got addr_b=%0d din_b=%02h, required addr_b=%0d din_b=%02h",
                             addr_b, din_b, monEntry.addr, monEntry.data);
                end
                modelB[monEntry.addr] = monEntry.data;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic host_write(input logic [2:0] a, input logic [7:0] d);
        host_we   = 1'b1;
        host_addr = a;
        host_din  = d;
        tick();
        host_we   = 1'b0;
        modelA[a] = d;
    endtask

    // Queue the expected B writes, then pulse start for one edge.
    task automatic launch(input logic [2:0] s, input logic [2:0] d, input int l);
        logic [2:0] ia;
        logic [2:0] ib;
        wr_t        w;
        for (int k = 0; k < l; k++) begin
            ia = s + 3'(k);
            ib = d + 3'(k);
            w.addr = ib;
            w.data = modelA[ia];
            expQ.push_back(w);
        end
        src_base = s;
        dst_base = d;
        len      = 4'(l);
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Observe a running copy until done, recording the cycle count and window checks.
    task automatic wait_done(input int l, output int n, output bit busyOk, output bit weOk, output bit weaOk);
        n = 0;
        busyOk = 1'b1;
        weOk = 1'b1;
        weaOk = 1'b1;
        while (done !== 1'b1 && n < 40) begin
            if (busy !== ((l > 0) && (n <= l))) busyOk = 1'b0;
            if (we_b !== ((n >= 1) && (n <= l))) weOk = 1'b0;
            if (we_a !== 1'b0) weaOk = 1'b0;
            tick();
            n++;
        end
        if (done !== 1'b1) n = -1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        start     = 1'b0;
        src_base  = '0;
        dst_base  = '0;
        len       = '0;
        host_we   = 1'b0;
        host_addr = '0;
        host_din  = '0;
        for (int i = 0; i < 8; i++) begin
            memA[i]   = 8'h00;
            modelA[i] = 8'h00;
            memB[i]   = 8'hA0 + 8'(i);
            modelB[i] = 8'hA0 + 8'(i);
        end
        repeat (2) @(posedge clock);
        #1;
        compared++;
        if ({busy, done, host_rej, we_b} !== 4'b0000) begin
            mismatched++;
            $display("[TB] FAIL reset_flags: got busy/done/rej/we_b=%b, required 0000", {busy, done, host_rej, we_b});
        end
        compared++;
        if (addr_b !== 3'd0 || din_b !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL reset_b_port: got addr_b=%0d din_b=%02h, required 0/00", addr_b, din_b);
        end
        compared++;
        if (checksum !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL reset_checksum: got %02h, required 00", checksum);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_full_copy();
        int n;
        bit bOk, wOk, aOk;
        for (int i = 0; i < 8; i++) host_write(3'(i), 8'h10 + 8'(i));
        host_addr = 3'd5;
        tick();
        compared++;
        if (host_dout !== 8'h15) begin
            mismatched++;
            $display("[TB] FAIL full_host_read: got %02h, required 15", host_dout);
        end
        launch(3'd0, 3'd0, 8);
        wait_done(8, n, bOk, wOk, aOk);
        compared++;
        if (n !== 9) begin
            mismatched++;
            $display("[TB] FAIL full_done_latency: got %0d, required 9 cycles after the start cycle", n);
        end
        compared++;
        if ({bOk, wOk, aOk} !== 3'b111) begin
            mismatched++;
            $display("[TB] FAIL full_windows: got busy/we_b/we_a ok=%b, required 111", {bOk, wOk, aOk});
        end
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL full_busy_at_done: got %b, required 0", busy);
        end
        tick();
        compared++;
        if (done !== 1'b0 || expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL full_after_done: got done=%b pending=%0d, required 0/0", done, expQ.size());
        end
        for (int i = 0; i < 8; i++) begin
            compared++;
            if (memB[i] !== 8'h10 + 8'(i)) begin
                mismatched++;
                $display("[TB] FAIL full_memB[%0d]: got %02h, required %02h", i, memB[i], 8'h10 + 8'(i));
            end
        end
    endtask

    task automatic test_wrap();
        int n;
        bit bOk, wOk, aOk;
        for (int i = 0; i < 8; i++) begin
            memB[i]   = 8'hC0 + 8'(i);
            modelB[i] = 8'hC0 + 8'(i);
        end
        launch(3'd6, 3'd5, 4);
        wait_done(4, n, bOk, wOk, aOk);
        compared++;
        if (n !== 5 || {bOk, wOk, aOk} !== 3'b111) begin
            mismatched++;
            $display("[TB] FAIL wrap_timing: got n=%0d ok=%b, required n=5 ok=111", n, {bOk, wOk, aOk});
        end
        tick();
        for (int i = 0; i < 8; i++) begin
            compared++;
            if (memB[i] !== modelB[i]) begin
                mismatched++;
                $display("[TB] FAIL wrap_memB[%0d]: got %02h, required %02h", i, memB[i], modelB[i]);
            end
        end
    endtask

    task automatic test_zero_len();
        int n;
        bit bOk, wOk, aOk;
        launch(3'd0, 3'd2, 0);
        wait_done(0, n, bOk, wOk, aOk);
        compared++;
        if (n !== 0 || wOk !== 1'b1 || aOk !== 1'b1 || busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL zero_len: got n=%0d we_b_ok=%b we_a_ok=%b busy=%b, required 0/1/1/0", n, wOk, aOk, busy);
        end
        tick();
        for (int i = 0; i < 8; i++) begin
            compared++;
            if (memB[i] !== modelB[i]) begin
                mismatched++;
                $display("[TB] FAIL zero_memB[%0d]: got %02h, required %02h", i, memB[i], modelB[i]);
            end
        end
    endtask

    task automatic test_host_lockout();
        int doneCount = 0;
        bit weaOk = 1'b1;
        launch(3'd2, 3'd3, 5);
        for (int c = 0; c < 20; c++) begin
            if (c == 2 || c == 3) begin
                compared++;
                if (host_rej !== (c == 3)) begin
                    mismatched++;
                    $display("[TB] FAIL lock_host_rej c%0d: got %b, required %b", c, host_rej, (c == 3));
                end
            end
            if (done === 1'b1) doneCount++;
            host_we = (c == 2);
            start   = (c == 2);
            if (c == 2) begin
                host_addr = 3'd3;
                host_din  = 8'hFF;
                src_base  = 3'd0;
                dst_base  = 3'd0;
                len       = 4'd8;
            end
            #1;
            if (we_a !== 1'b0) weaOk = 1'b0;
            tick();
        end
        host_we = 1'b0;
        start   = 1'b0;
        compared++;
        if (doneCount !== 1 || weaOk !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL lock_done_count: got dones=%0d we_a_ok=%b, required 1/1", doneCount, weaOk);
        end
        host_addr = 3'd3;
        tick();
        compared++;
        if (host_dout !== modelA[3]) begin
            mismatched++;
            $display("[TB] FAIL lock_A3: got %02h, required %02h", host_dout, modelA[3]);
        end
        for (int i = 0; i < 8; i++) begin
            compared++;
            if (memB[i] !== modelB[i]) begin
                mismatched++;
                $display("[TB] FAIL lock_memB[%0d]: got %02h, required %02h", i, memB[i], modelB[i]);
            end
        end
    endtask

    task automatic test_reset_midop();
        int n;
        bit bOk, wOk, aOk;
        launch(3'd1, 3'd4, 6);
        repeat (3) tick();
        compared++;
        if (we_b !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL midop_pre_we_b: got %b, required 1", we_b);
        end
        reset_n = 1'b0;
        #1;
        compared++;
        if (we_b !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL midop_async_clear: got we_b=%b busy=%b, required 0/0", we_b, busy);
        end
        expQ.delete();
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            compared++;
            if (memB[i] !== modelB[i]) begin
                mismatched++;
                $display("[TB] FAIL midop_memB[%0d]: got %02h, required %02h", i, memB[i], modelB[i]);
            end
        end
        launch(3'd0, 3'd6, 3);
        wait_done(3, n, bOk, wOk, aOk);
        compared++;
        if (n !== 4 || {bOk, wOk, aOk} !== 3'b111) begin
            mismatched++;
            $display("[TB] FAIL midop_restart: got n=%0d ok=%b, required n=4 ok=111", n, {bOk, wOk, aOk});
        end
        tick();
        for (int i = 0; i < 8; i++) begin
            compared++;
            if (memB[i] !== modelB[i]) begin
                mismatched++;
                $display("[TB] FAIL restart_memB[%0d]: got %02h, required %02h", i, memB[i], modelB[i]);
            end
        end
    endtask

    task automatic test_checksum();
        int n;
        bit bOk, wOk, aOk;
        logic [7:0] expCk;
        host_write(3'd0, 8'hFF);
        host_write(3'd1, 8'h02);
        host_write(3'd2, 8'h01);
`ifdef XFER_CHECKSUM_EN
        expCk = 8'h02;
`else
        expCk = 8'h00;
`endif
        launch(3'd0, 3'd0, 3);
        wait_done(3, n, bOk, wOk, aOk);
        compared++;
        if (n !== 4 || checksum !== expCk) begin
            mismatched++;
            $display("[TB] FAIL cksum_at_done: got n=%0d checksum=%02h, required n=4 checksum=%02h", n, checksum, expCk);
        end
        repeat (3) tick();
        compared++;
        if (checksum !== expCk) begin
            mismatched++;
            $display("[TB] FAIL cksum_held: got %02h, required %02h", checksum, expCk);
        end
        for (int i = 0; i < 3; i++) begin
            compared++;
            if (memB[i] !== modelB[i]) begin
                mismatched++;
                $display("[TB] FAIL cksum_memB[%0d]: got %02h, required %02h", i, memB[i], modelB[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_copy();
        test_wrap();
        test_zero_len();
        test_host_lockout();
        test_reset_midop();
        test_checksum();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
